dcache_ecc_monitor: RTL
=======================

Name: dcache_ecc_monitor

Overview:
- Sits directly downstream of the non-blocking L1 dcache's tag-compare/ECC stage.
- Consumes the 6-bit per-cycle ECC event strobes and the faulting index address produced there.
- Accumulates saturating per-event counters and logs error events into a small FIFO that software drains through a valid/ready pop port.
- Raises an interrupt when uncorrectable errors reach a threshold.

Parameters:
- NumEvents, 6, number of ECC event strobes (fixed mapping below)
- CntWidth, 32, width of each saturating event counter
- AddrWidth, 12, width of the logged index address (equals DCACHE_INDEX_WIDTH)
- LogDepth, 4, log FIFO entries (power of two, >=2)
- UeThreshold, 1, total uncorrectable count at which irq_o asserts (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  monitor enable; when low, events are ignored, state held
- event_i  in  NumEvents  ECC strobes: [0] data SEC, [1] data DED, [2] tag SEC, [3] tag DED, [4] valid/dirty SEC, [5] valid/dirty DED
- err_addr_i  in  AddrWidth  dcache index of the access producing event_i, same cycle
- clear_i  in  1  one-cycle pulse: zero counters, flush log, clear sticky flags and irq
- cnt_sel_i  in  3  counter read select (0..5 events, 6 dropped-log count, 7 total UE)
- cnt_o  out  CntWidth  selected counter, combinational from registers
- log_valid_o  out  1  log head valid
- log_ready_i  in  1  pop handshake
- log_addr_o  out  AddrWidth  head entry address
- log_mask_o  out  NumEvents  head entry event mask
- log_overflow_o  out  1  sticky: at least one entry dropped
- irq_o  out  1  registered interrupt

Behaviour:
- Reset (rst_i high at a clock edge): all counters 0; FIFO empty; log_valid_o=0; log_overflow_o=0; irq_o=0; log_addr_o/log_mask_o=0.
- Event capture: when enable_i=1 and event_i!=0, each set bit increments its counter by 1 at the next edge. Simultaneous bits are all counted.
- Counter saturation: counters saturate at all-ones and never wrap.
- Total UE counter: increments by popcount(event_i[1],[3],[5]) (0..3), saturating.
- Counter latency: 1 cycle, event to visible cnt_o.
- Logging: when enable_i=1 and event_i!=0, push one entry {err_addr_i, event_i}.
- FIFO full with no pop: the entry is dropped, the dropped counter increments (saturating), and log_overflow_o sets.
- FIFO full with a simultaneous pop (log_valid_o & log_ready_i): both the pop and the push take effect; nothing is dropped.
- FIFO empty with a simultaneous push: entry becomes visible next cycle (no fall-through); log_valid_o rises 1 cycle after the push.
- Pop: the head advances on log_valid_o & log_ready_i. log_ready_i while empty is ignored.
- Pointers: wrap modulo LogDepth; a separate count register, 0..LogDepth, distinguishes full from empty.
- irq_o: set at the edge where the registered total UE >= UeThreshold is first reached; it then stays high until clear_i or reset.
- clear_i priority: clear_i wins over any same-cycle event, push or pop. That cycle's event is discarded, and all state goes to reset values at the next edge.
- enable_i low: no counting or logging, but pop and clear still operate.
- Reset mid-operation: FIFO contents are discarded and pending entries are lost. There is no partial-state requirement.

Optional Feature:
- Macro: DCACHE_ECC_MON_TIMESTAMP_EN.
- When defined: adds a free-running 32-bit cycle counter (reset 0, wraps) and a log_ts_o output (out, 32). Each entry stores the counter value of its push cycle.
- When undefined: no counter, no log_ts_o port, and entry width is AddrWidth+NumEvents.

Decomposition:
- std_cache_pkg additions:
  - enum ecc_evt_e: DATA_SEC=0, DATA_DED, TAG_SEC, TAG_DED, VD_SEC, VD_DED
  - localparam ECC_UE_MASK=6'b101010
  - struct ecc_log_entry_t {addr, mask[, ts]}
- One sub-module, dcache_ecc_log_fifo: parameterised depth and entry type; push/pop/full/empty/count; synchronous active-high reset and flush.

Test Plan:
- Single SEC: event_i=6'b000001, err_addr_i=12'h0A4 for one cycle → next cycle cnt_o(sel 0)=1, log_valid_o=1, log_addr_o=12'h0A4, log_mask_o=6'b000001, irq_o=0.
- Multi-bit: event_i=6'b101010 one cycle, UeThreshold=2 → counters 1,3,5 each =1; total UE (sel 7)=3; irq_o=1 next cycle, held until clear_i.
- Overflow: 6 consecutive events at addr 0..5 with log_ready_i=0, LogDepth=4 → 4 entries (addr 0..3); dropped (sel 6)=2; log_overflow_o=1. Popping 4 times yields addr 0,1,2,3 in order, then log_valid_o=0.
- Full push+pop: fill 4 entries, then one cycle with event (addr 12'h0FF) and log_ready_i=1 → dropped stays 0; FIFO holds 4 entries; last pop returns 12'h0FF.
- Saturation/clear: CntWidth=4, 20 events on bit 2 → sel 2 reads 4'hF. clear_i together with an event → all counters 0, log empty, irq_o=0, and the event is not counted.
- Enable gating: enable_i=0 with event_i=6'b111111 for 10 cycles → all counters 0, log_valid_o=0.

Source files
------------

// File: rtl/dcache_ecc_monitor_pkg.sv
// dcache_ecc_monitor_pkg: ECC event encoding and log entry type (ts field under DCACHE_ECC_MON_TIMESTAMP_EN)
package dcache_ecc_monitor_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int ECC_NUM_EVENTS = 6;
  typedef enum logic [2:0] {DATA_SEC, DATA_DED, TAG_SEC, TAG_DED, VD_SEC, VD_DED} ecc_evt_e;
  localparam logic [ECC_NUM_EVENTS-1:0] ECC_UE_MASK = 6'b101010;
  localparam logic [2:0] CNT_DROP = 3'd6;
  localparam logic [2:0] CNT_UE = 3'd7;
  typedef struct packed {
`ifdef DCACHE_ECC_MON_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [DCACHE_INDEX_WIDTH-1:0] addr;
    logic [ECC_NUM_EVENTS-1:0] mask;
  } ecc_log_entry_t;
endpackage

// File: rtl/dcache_ecc_log_fifo.sv
// dcache_ecc_log_fifo: power-of-two FIFO with occupancy count, sync reset and flush
module dcache_ecc_log_fifo #(
  parameter int Depth = 4,
  parameter type entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic do_push, do_pop;
  entry_t mem_q [Depth];
  assign full_o = count_q == CntW'(Depth);
  assign empty_o = count_q == '0;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = empty_o ? '0 : mem_q[rptr_q];
  always_ff @(posedge clk_i) begin
    if (rst_i | flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_q + PtrW'(do_push);
      rptr_q <= rptr_q + PtrW'(do_pop);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wptr_q] <= data_i;
endmodule

// File: rtl/dcache_ecc_monitor.sv
// dcache_ecc_monitor: saturating ECC event counters, error log FIFO and UE interrupt (DCACHE_ECC_MON_TIMESTAMP_EN adds log_ts_o)
module dcache_ecc_monitor
  import dcache_ecc_monitor_pkg::*;
#(
  parameter int NumEvents = ECC_NUM_EVENTS,
  parameter int CntWidth = 32,
  parameter int AddrWidth = DCACHE_INDEX_WIDTH,
  parameter int LogDepth = 4,
  parameter int UeThreshold = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NumEvents-1:0] event_i,
  input  logic [AddrWidth-1:0] err_addr_i,
  input  logic                 clear_i,
  input  logic [2:0]           cnt_sel_i,
  output logic [CntWidth-1:0]  cnt_o,
  output logic                 log_valid_o,
  input  logic                 log_ready_i,
  output logic [AddrWidth-1:0] log_addr_o,
  output logic [NumEvents-1:0] log_mask_o,
  output logic                 log_overflow_o,
`ifdef DCACHE_ECC_MON_TIMESTAMP_EN
  output logic [31:0]          log_ts_o,
`endif
  output logic                 irq_o
);
  logic [CntWidth-1:0] cnt_q [8];
  logic [CntWidth-1:0] cnt_d [8];
  logic [1:0] inc [8];
  logic active, pop, full, empty, drop, ovf_q, irq_q, irq_d;
  ecc_log_entry_t wr_entry, rd_entry;
  assign active = enable_i & |event_i & ~clear_i;
  assign pop = ~empty & log_ready_i;
  assign drop = active & full & ~pop;
  always_comb begin
    for (int i = 0; i < NumEvents; i++) inc[i] = {1'b0, active & event_i[i]};
    inc[CNT_DROP] = {1'b0, drop};
    inc[CNT_UE] = active ? 2'($countones(event_i & ECC_UE_MASK)) : 2'd0;
    for (int i = 0; i < 8; i++)
      cnt_d[i] = (cnt_q[i] > '1 - CntWidth'(inc[i])) ? '1 : cnt_q[i] + CntWidth'(inc[i]);
    irq_d = irq_q | (cnt_d[CNT_UE] >= CntWidth'(UeThreshold));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_q | drop;
      irq_q <= irq_d;
    end
  end
  assign wr_entry.addr = err_addr_i;
  assign wr_entry.mask = event_i;
`ifdef DCACHE_ECC_MON_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk_i) ts_q <= rst_i ? 32'd0 : ts_q + 32'd1;
  assign wr_entry.ts = ts_q;
  assign log_ts_o = rd_entry.ts;
`endif
  dcache_ecc_log_fifo #(.Depth(LogDepth), .entry_t(ecc_log_entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (active),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .data_o  (rd_entry),
    .full_o  (full),
    .empty_o (empty)
  );
  assign cnt_o = cnt_q[cnt_sel_i];
  assign log_valid_o = ~empty;
  assign log_addr_o = rd_entry.addr;
  assign log_mask_o = rd_entry.mask;
  assign log_overflow_o = ovf_q;
  assign irq_o = irq_q;
endmodule
